// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO read-side drain sequencer.
package fifo_drain_pkg;

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RUN     = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } drain_state_e;

  // Cycles spent in STARTUP after reset; masks the FIFO's rempty=0 out of reset.
  localparam int STARTUP_CYC = 2;

  localparam int DEF_RD_LAT    = 2;
  localparam int DEF_BUF_DEPTH = 4;

endpackage

// File: rtl/drain_skid_buf.sv
// Circular skid buffer that absorbs the words already in flight from the FIFO.
// The caller guarantees no push when full and no pop when empty.
module drain_skid_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   occ_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] occ_q;

  // Storage, pointers (wrapping modulo DEPTH) and occupancy update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side sequencer: drains exactly len words from the FIFO, tracking the
// FIFO's registered read latency, and hands them to a consumer.
// Consumer port: a word transfers on every cycle with out_valid_o && out_ready_i;
// out_valid_o never depends on out_ready_i, and out_last_o is meaningful only
// while out_valid_o is high.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LEN_W     = 8,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [LEN_W-1:0]             len_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         rinc_o,
  input  logic                         rempty_i,
  input  logic [WIDTH-1:0]             rdata_i,
  output logic                         out_valid_o,
  output logic [WIDTH-1:0]             out_data_o,
  output logic                         out_last_o,
  input  logic                         out_ready_i,
  output drain_state_e                 state_o,
  output logic [$clog2(BUF_DEPTH):0]   occ_o
);

  localparam int OCC_W = $clog2(BUF_DEPTH) + 1;
  localparam int SUM_W = OCC_W + 1;
  localparam logic [1:0] STARTUP_LAST = 2'(STARTUP_CYC - 1);

  drain_state_e     state_q, state_d;
  logic [1:0]       startup_cnt_q, startup_cnt_d;
  logic [LEN_W-1:0] issue_left_q, issue_left_d;
  logic [LEN_W-1:0] deliver_left_q, deliver_left_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] inflight;
  logic [SUM_W-1:0] pending;
  logic [WIDTH-1:0] head;
  logic             rinc, busy, done, room, out_valid, handshake;

  drain_skid_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (rd_pipe_q[RD_LAT-1]),
    .push_data_i (rdata_i),
    .pop_i       (handshake),
    .occ_o       (occ),
    .head_o      (head)
  );

  // Words issued but not yet in the buffer: popcount of the latency pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OCC_W'(rd_pipe_q[i]);
  end

  // A read may only be issued if its word is sure to find a free buffer slot.
  assign pending   = SUM_W'(occ) + SUM_W'(inflight);
  assign room      = pending < SUM_W'(BUF_DEPTH);
  assign out_valid = occ != '0;
  assign handshake = out_valid && out_ready_i;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_STARTUP;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STARTUP: if (startup_cnt_q == STARTUP_LAST) state_d = ST_IDLE;
      ST_IDLE:    if (start_i) state_d = (len_i == '0) ? ST_DONE : ST_RUN;
      ST_RUN:     if (rinc && issue_left_q == LEN_W'(1)) state_d = ST_FLUSH;
      ST_FLUSH:   if (deliver_left_q == '0) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_STARTUP;
    endcase
  end

  // FSM outputs; rinc is confined to RUN and gated by rempty.
  always_comb begin
    rinc = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        busy = 1'b1;
        rinc = !rempty_i && (issue_left_q != '0) && room;
      end
      ST_FLUSH: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Next values of the transfer counters, startup counter and latency pipe.
  always_comb begin
    startup_cnt_d  = startup_cnt_q;
    issue_left_d   = issue_left_q;
    deliver_left_d = deliver_left_q;
    rd_pipe_d      = rd_pipe_q << 1;
    rd_pipe_d[0]   = rinc;
    if (state_q == ST_STARTUP) startup_cnt_d = startup_cnt_q + 1'b1;
    if (state_q == ST_IDLE && start_i) begin
      issue_left_d   = len_i;
      deliver_left_d = len_i;
    end else begin
      if (rinc) issue_left_d = issue_left_q - 1'b1;
      if (handshake && deliver_left_q != '0) deliver_left_d = deliver_left_q - 1'b1;
    end
  end

  // Counter and latency-pipe registers; reset drops any in-flight read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      startup_cnt_q  <= '0;
      issue_left_q   <= '0;
      deliver_left_q <= '0;
      rd_pipe_q      <= '0;
    end else begin
      startup_cnt_q  <= startup_cnt_d;
      issue_left_q   <= issue_left_d;
      deliver_left_q <= deliver_left_d;
      rd_pipe_q      <= rd_pipe_d;
    end
  end

  assign busy_o      = busy;
  assign done_o      = done;
  assign rinc_o      = rinc;
  assign out_valid_o = out_valid;
  assign out_data_o  = head;
  assign out_last_o  = out_valid && (deliver_left_q == LEN_W'(1));
  assign state_o     = state_q;
  assign occ_o       = occ;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: FIFO model upstream, transaction-level model of
// the drain behaviour, per-cycle comparison plus directed literal checks.
module tb_fifo_drain_ctrl;
  import fifo_drain_pkg::*;

  localparam int WIDTH     = 8;
  localparam int LEN_W     = 8;
  localparam int BUF_DEPTH = 4;
  localparam int RD_LAT    = 2;
  localparam int BUDGET    = 2000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, start, rempty, out_ready;
  logic [LEN_W-1:0]         len;
  logic [WIDTH-1:0]         rdata;
  logic                     busy, done, rinc, out_valid, out_last;
  logic [WIDTH-1:0]         out_data;
  drain_state_e             state;
  logic [$clog2(BUF_DEPTH):0] occ;

  fifo_drain_ctrl #(
    .WIDTH(WIDTH), .LEN_W(LEN_W), .BUF_DEPTH(BUF_DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
    .busy_o(busy), .done_o(done), .rinc_o(rinc),
    .rempty_i(rempty), .rdata_i(rdata),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
    .out_ready_i(out_ready), .state_o(state), .occ_o(occ)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // stimulus intent, applied at the next falling edge
  logic             rst_b = 1'b1;
  logic             start_b = 1'b0;
  logic [LEN_W-1:0] len_b = '0;
  int               ready_pct = 100;
  bit               force_nonempty = 1'b1;

  // upstream FIFO model: 2-cycle registered read
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] fifo_stage1 = '0;
  logic [WIDTH-1:0] fifo_rdata = '0;
  int               supply_left = 0;
  int               supply_pct = 100;
  logic [WIDTH-1:0] next_word = 8'h80;

  // transfer model: words issued and not yet consumed, with visibility cycle
  logic [WIDTH-1:0] exp_q[$];
  int               vis_q[$];
  int               startup_left = STARTUP_CYC;
  bit               active = 1'b0;
  int               m_len = 0, m_issued = 0, m_delivered = 0;
  int               done_cyc = -1;

  // observations of the DUT for directed checks
  int               obs_rinc, obs_hs, obs_done, first_valid;
  logic [WIDTH-1:0] got_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit model_idle();
    return (startup_left == 0) && !active && (done_cyc < 0);
  endfunction

  task automatic clear_obs();
    obs_rinc = 0; obs_hs = 0; obs_done = 0; first_valid = -1;
    got_q.delete();
  endtask

  // one clock cycle: drive, compare against the model, advance the model
  task automatic tick();
    bit e_rinc, e_valid, e_done, e_busy, hs, idle;
    int nvis;
    logic [WIDTH-1:0] w;
    @(negedge clk);
    cyc++;
    if (supply_left > 0 && $urandom_range(99) < supply_pct) begin
      fifo_q.push_back(next_word);
      next_word++;
      supply_left--;
    end
    rst       = rst_b;
    start     = start_b;
    len       = len_b;
    out_ready = ($urandom_range(99) < ready_pct);
    rempty    = force_nonempty ? 1'b0 : (fifo_q.size() == 0);
    rdata     = fifo_rdata;
    #1;
    if (rinc === 1'b1) obs_rinc++;
    if (done === 1'b1) obs_done++;
    if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (out_valid === 1'b1 && out_ready) begin obs_hs++; got_q.push_back(out_data); end

    idle    = model_idle();
    e_rinc  = active && (m_issued < m_len) && !rempty && (exp_q.size() < BUF_DEPTH);
    e_valid = (vis_q.size() > 0) && (vis_q[0] <= cyc);
    e_done  = (cyc == done_cyc);
    e_busy  = active && !e_done;
    nvis = 0;
    foreach (vis_q[i]) if (vis_q[i] <= cyc) nvis++;

    chk("rinc", rinc, e_rinc);
    chk("no_rinc_when_empty", rinc && rempty, 0);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("out_valid", out_valid, e_valid);
    chk("occ", occ, nvis);
    if (e_valid) begin
      chk("out_data", out_data, exp_q[0]);
      chk("out_last", out_last, (m_delivered == m_len - 1));
    end else begin
      chk("out_last_unqualified", out_last, 0);
    end

    hs = e_valid && out_ready;
    if (rst) begin
      startup_left = STARTUP_CYC;
      active = 1'b0; done_cyc = -1;
      exp_q.delete(); vis_q.delete();
      fifo_stage1 = '0; fifo_rdata = '0;
    end else begin
      if (startup_left > 0) startup_left--;
      fifo_rdata = fifo_stage1;
      if (hs) begin
        void'(exp_q.pop_front());
        void'(vis_q.pop_front());
        m_delivered++;
      end
      if (e_rinc) begin
        w = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
        fifo_stage1 = w;
        exp_q.push_back(w);
        vis_q.push_back(cyc + RD_LAT + 1);
        m_issued++;
      end
      if (e_done) begin active = 1'b0; done_cyc = -1; end
      if (hs && m_delivered == m_len) done_cyc = cyc + 2;
      if (idle && start) begin
        m_len = int'(len); m_issued = 0; m_delivered = 0;
        if (len == '0) done_cyc = cyc + 1;
        else active = 1'b1;
      end
    end
  endtask

  task automatic run_until_idle(input bit spurious);
    int n = 0;
    while (!model_idle() && n < BUDGET) begin
      start_b = spurious && ($urandom_range(99) < 5);
      len_b   = LEN_W'($urandom);
      tick();
      n++;
    end
    start_b = 1'b0;
    checks++;
    if (!model_idle()) begin
      errors++;
      $display("FAIL completion_budget cycle=%0d actual=busy expected=idle", cyc);
    end
  endtask

  task automatic start_xfer(input int n);
    start_b = 1'b1; len_b = LEN_W'(n);
    tick();
    start_b = 1'b0;
  endtask

  initial begin
    int s;
    rst = 1'b1; start = 1'b0; len = '0; out_ready = 1'b0; rempty = 1'b0; rdata = '0;

    // reset / startup with rempty held low
    clear_obs();
    repeat (3) begin
      tick();
      chk("reset_out_data", out_data, 0);
    end
    rst_b = 1'b0;
    tick();
    chk("startup_state", state, ST_STARTUP);
    tick();
    force_nonempty = 1'b0;
    tick();
    chk("startup_no_rinc", obs_rinc, 0);

    // basic drain of 0x10..0x14
    ready_pct = 100;
    clear_obs();
    for (int i = 0; i < 5; i++) fifo_q.push_back(WIDTH'(8'h10 + i));
    start_xfer(5);
    s = cyc;
    run_until_idle(1'b0);
    chk("basic_rinc_count", obs_rinc, 5);
    chk("basic_done_count", obs_done, 1);
    chk("basic_first_valid_latency", first_valid - s, 4);
    chk("basic_word_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) chk("basic_word", got_q[i], 8'h10 + i);

    // empty stall: one word now, two more 10 cycles later
    clear_obs();
    fifo_q.push_back(8'h20);
    start_xfer(3);
    repeat (10) tick();
    fifo_q.push_back(8'h21);
    fifo_q.push_back(8'h22);
    run_until_idle(1'b0);
    chk("stall_words", obs_hs, 3);
    chk("stall_rinc_count", obs_rinc, 3);
    chk("stall_last_word", got_q.size() == 3 ? got_q[2] : 8'hxx, 8'h22);

    // backpressure: 10 words with consumer stalled for 20 cycles
    clear_obs();
    for (int i = 0; i < 10; i++) fifo_q.push_back(WIDTH'(8'h30 + i));
    ready_pct = 0;
    start_xfer(10);
    repeat (20) tick();
    chk("bp_rinc_count", obs_rinc, 4);
    chk("bp_occ", occ, 4);
    chk("bp_no_handshake", obs_hs, 0);
    ready_pct = 100;
    run_until_idle(1'b0);
    chk("bp_word_count", got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) chk("bp_word", got_q[i], 8'h30 + i);

    // zero length
    clear_obs();
    start_xfer(0);
    chk("zero_no_done_yet", obs_done, 0);
    tick();
    chk("zero_done_next", obs_done, 1);
    run_until_idle(1'b0);
    chk("zero_no_rinc", obs_rinc, 0);

    // start during RUN is ignored
    clear_obs();
    for (int i = 0; i < 6; i++) fifo_q.push_back(WIDTH'(8'h40 + i));
    start_xfer(4);
    tick();
    start_b = 1'b1; len_b = 8'd9;
    tick();
    start_b = 1'b0;
    run_until_idle(1'b0);
    chk("ignored_start_words", obs_hs, 4);
    chk("ignored_start_done", obs_done, 1);
    fifo_q.delete();

    // reset in FLUSH with two reads in flight
    clear_obs();
    for (int i = 0; i < 3; i++) fifo_q.push_back(WIDTH'(8'h50 + i));
    start_xfer(3);
    repeat (3) tick();
    rst_b = 1'b1;
    tick();
    chk("midrst_in_flush", state, ST_FLUSH);
    rst_b = 1'b0;
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_state", state, ST_STARTUP);
    run_until_idle(1'b0);
    fifo_q.delete();
    clear_obs();
    fifo_q.push_back(8'h60);
    fifo_q.push_back(8'h61);
    start_xfer(2);
    run_until_idle(1'b0);
    chk("after_rst_words", got_q.size(), 2);
    chk("after_rst_word0", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h60);
    chk("after_rst_done", obs_done, 1);

    // randomized transfers with trickling supply, random backpressure, stray starts
    for (int t = 0; t < 16; t++) begin
      int n;
      n = $urandom_range(0, 24);
      supply_left = n;
      supply_pct  = $urandom_range(30, 100);
      ready_pct   = $urandom_range(20, 100);
      start_xfer(n);
      run_until_idle(1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
